// File: rtl/pix_wr_if.sv
// Pixel-stream input and memory write port of the frame buffer write packer.
// The master side feeds pixels and wr_rdy; the slave side (the packer) issues write requests.
interface pix_wr_if #(
    parameter int PIX_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  frame_start;
    logic                  pix_valid;
    logic [PIX_WIDTH-1:0]  pix_data;
    logic                  wr_rdy;
    logic                  mem_wr_req_n;
    logic [DATA_WIDTH-1:0] mem_wr_data;

    modport master (
        output frame_start, pix_valid, pix_data, wr_rdy,
        input  mem_wr_req_n, mem_wr_data
    );

    modport slave (
        input  frame_start, pix_valid, pix_data, wr_rdy,
        output mem_wr_req_n, mem_wr_data
    );
endinterface

// File: rtl/pix_wr_packer.sv
// Packs a pixel stream into memory words, queues them in a small FWFT FIFO and writes them out.
// Optional macro PIX_PACK_DROP_CNT_EN adds the drop_cnt and frame_cnt counters.
module pix_wr_packer #(
    parameter int PIX_WIDTH    = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int FRAME_PIXELS = 307200,
    parameter int PCNT_WIDTH   = 20
) (
    input  logic                        wr_clk,
    input  logic                        reset,
    pix_wr_if.slave                     bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        overflow,
    output logic                        sync_err
`ifdef PIX_PACK_DROP_CNT_EN
    ,
    output logic [15:0]                 drop_cnt,
    output logic [15:0]                 frame_cnt
`endif
);
    localparam int PPW = DATA_WIDTH / PIX_WIDTH;
    localparam int LW  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LVW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                 state_r, state_next_s;
    logic [PCNT_WIDTH-1:0]  cnt_r, cnt_next_s, base_cnt_s, cnt_inc_s;
    logic [LW-1:0]          lane_r, lane_next_s, base_lane_s;
    logic [DATA_WIDTH-1:0]  word_r, word_next_s, base_word_s, packed_s, push_word_s;
    logic                   accept_s, push_s, sync_set_s, done_s;

    logic [DATA_WIDTH-1:0]  mem_r [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_r, rd_ptr_r;
    logic [LVW-1:0]         level_r, level_next_s;
    logic                   req_n_r, busy_r, done_r, ovf_r, sync_r;
    logic                   pop_s, full_s, wr_en_s, drop_s;

    // Frame sequencing and pixel packing: next state, counters, and the word to push
    always_comb begin
        state_next_s = state_r;
        base_cnt_s   = cnt_r;
        base_lane_s  = lane_r;
        base_word_s  = word_r;
        accept_s     = 1'b0;
        push_s       = 1'b0;
        push_word_s  = word_r;
        sync_set_s   = 1'b0;
        done_s       = 1'b0;
        // A frame_start always restarts packing from lane 0; outside IDLE it aborts the frame
        if (bus.frame_start) begin
            state_next_s = ST_PACK;
            base_cnt_s   = '0;
            base_lane_s  = '0;
            base_word_s  = '0;
            accept_s     = bus.pix_valid;
            sync_set_s   = (state_r != ST_IDLE);
        end else begin
            case (state_r)
                ST_IDLE:  accept_s = 1'b0;
                ST_PACK:  accept_s = bus.pix_valid;
                ST_FLUSH: begin
                    push_s       = 1'b1;
                    push_word_s  = word_r;
                    base_word_s  = '0;
                    base_lane_s  = '0;
                    state_next_s = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (level_r == LVW'(0)) begin
                        done_s       = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_DRAIN;
                    end
                end
                default:  state_next_s = ST_IDLE;
            endcase
        end

        packed_s = base_word_s;
        for (int i = 0; i < PPW; i++) begin
            if (base_lane_s == LW'(i)) begin
                packed_s[i*PIX_WIDTH +: PIX_WIDTH] = bus.pix_data;
            end else begin
                packed_s[i*PIX_WIDTH +: PIX_WIDTH] = base_word_s[i*PIX_WIDTH +: PIX_WIDTH];
            end
        end

        cnt_inc_s   = base_cnt_s + PCNT_WIDTH'(1);
        cnt_next_s  = base_cnt_s;
        lane_next_s = base_lane_s;
        word_next_s = base_word_s;
        if (accept_s) begin
            cnt_next_s = cnt_inc_s;
            if (base_lane_s == LW'(PPW - 1)) begin
                push_s      = 1'b1;
                push_word_s = packed_s;
                word_next_s = '0;
                lane_next_s = '0;
            end else begin
                word_next_s = packed_s;
                lane_next_s = base_lane_s + LW'(1);
            end
            if (cnt_inc_s == PCNT_WIDTH'(FRAME_PIXELS)) begin
                state_next_s = (lane_next_s == LW'(0)) ? ST_DRAIN : ST_FLUSH;
            end else begin
                state_next_s = ST_PACK;
            end
        end else begin
            cnt_next_s = base_cnt_s;
        end
    end

    // FIFO control: a pop frees the slot a simultaneous push uses, so full+pop+push never drops
    always_comb begin
        pop_s        = (level_r != LVW'(0)) && bus.wr_rdy;
        full_s       = (level_r == LVW'(FIFO_DEPTH));
        wr_en_s      = push_s && (!full_s || pop_s);
        drop_s       = push_s && full_s && !pop_s;
        level_next_s = level_r + LVW'(wr_en_s) - LVW'(pop_s);
    end

    // Packer state, counters and the partial word
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            lane_r  <= '0;
            word_r  <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            lane_r  <= lane_next_s;
            word_r  <= word_next_s;
        end
    end

    // FIFO storage; contents are only observable through the level-qualified head read
    always_ff @(posedge wr_clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_word_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, level and the registered status outputs
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            req_n_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
            sync_r   <= 1'b0;
        end else begin
            wr_ptr_r <= wr_en_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
            rd_ptr_r <= pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
            level_r  <= level_next_s;
            req_n_r  <= (level_next_s == LVW'(0));
            busy_r   <= (state_next_s != ST_IDLE);
            done_r   <= done_s;
            ovf_r    <= ovf_r | drop_s;
            sync_r   <= sync_r | sync_set_s;
        end
    end

    assign bus.mem_wr_req_n = req_n_r;
    assign bus.mem_wr_data  = (level_r == LVW'(0)) ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r];
    assign fifo_level       = level_r;
    assign busy             = busy_r;
    assign frame_done       = done_r;
    assign overflow         = ovf_r;
    assign sync_err         = sync_r;

`ifdef PIX_PACK_DROP_CNT_EN
    logic [15:0] drop_cnt_r, frame_cnt_r;

    // Saturating dropped-word counter and wrapping completed-frame counter
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            drop_cnt_r  <= 16'h0000;
            frame_cnt_r <= 16'h0000;
        end else begin
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'h0001;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
            frame_cnt_r <= done_s ? (frame_cnt_r + 16'h0001) : frame_cnt_r;
        end
    end

    assign drop_cnt  = drop_cnt_r;
    assign frame_cnt = frame_cnt_r;
`endif
endmodule

// File: tb/tb_pix_wr_packer.sv
// Self-checking bench for pix_wr_packer: directed frames plus random traffic against a queue-based model.
module tb_pix_wr_packer;
    localparam int PW     = 8;
    localparam int DW     = 32;
    localparam int PPW    = DW / PW;
    localparam int DEPTH  = 4;
    localparam int FRAME  = 10;
    localparam int M_IDLE = 0, M_PACK = 1, M_FLUSH = 2, M_DRAIN = 3;

    logic       wr_clk;
    logic       reset;
    logic [2:0] fifo_level;
    logic       busy, frame_done, overflow, sync_err;
`ifdef PIX_PACK_DROP_CNT_EN
    logic [15:0] drop_cnt, frame_cnt;
`endif

    pix_wr_if #(.PIX_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

    pix_wr_packer #(
        .PIX_WIDTH(PW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
        .FRAME_PIXELS(FRAME), .PCNT_WIDTH(20)
    ) dut (
        .wr_clk     (wr_clk),
        .reset      (reset),
        .bus        (bus),
        .fifo_level (fifo_level),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .sync_err   (sync_err)
`ifdef PIX_PACK_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt),
        .frame_cnt  (frame_cnt)
`endif
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: spec-level frame state, pixels of the open word, and the word queue
    int          m_state;
    int          m_cnt;
    logic [7:0]  m_pix [$];
    logic [31:0] m_fifo [$];
    bit          m_ovf, m_sync, m_done;
    int          m_drops, m_frames;

    logic [31:0] dut_words [$];
    int          done_seen;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [7:0] px [$]);
        logic [31:0] w;
        w = 32'h0000_0000;
        for (int i = 0; i < px.size(); i++) w = w | (32'(px[i]) << (8 * i));
        return w;
    endfunction

    task automatic model_clock();
        bit          was_empty, do_pop, full, have_push;
        logic [31:0] pw;
        if (reset) begin
            m_state = M_IDLE; m_cnt = 0; m_pix.delete(); m_fifo.delete();
            m_ovf = 0; m_sync = 0; m_done = 0; m_drops = 0; m_frames = 0;
            return;
        end
        was_empty = (m_fifo.size() == 0);
        full      = (m_fifo.size() == DEPTH);
        do_pop    = !was_empty && bus.wr_rdy;
        have_push = 0;
        pw        = 32'h0;
        m_done    = 0;
        if (bus.frame_start) begin
            if (m_state != M_IDLE) m_sync = 1;
            m_pix.delete();
            m_cnt   = 0;
            m_state = M_PACK;
        end else if (m_state == M_FLUSH) begin
            have_push = 1; pw = word_of(m_pix); m_pix.delete(); m_state = M_DRAIN;
        end else if (m_state == M_DRAIN && was_empty) begin
            m_done = 1; m_frames++; m_state = M_IDLE;
        end
        if (bus.pix_valid && m_state == M_PACK && (bus.frame_start || m_cnt < FRAME)) begin
            m_pix.push_back(bus.pix_data);
            m_cnt++;
            if (m_pix.size() == PPW) begin
                have_push = 1; pw = word_of(m_pix); m_pix.delete();
            end
            if (m_cnt == FRAME) m_state = (m_pix.size() == 0) ? M_DRAIN : M_FLUSH;
        end
        if (do_pop) void'(m_fifo.pop_front());
        if (have_push) begin
            if (!full || do_pop) m_fifo.push_back(pw);
            else begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end
        end
    endtask

    task automatic compare_outputs();
        check_eq("req_n", 32'(bus.mem_wr_req_n), 32'(m_fifo.size() == 0));
        if (m_fifo.size() != 0) check_eq("head_data", bus.mem_wr_data, m_fifo[0]);
        check_eq("level", 32'(fifo_level), 32'(m_fifo.size()));
        check_eq("busy", 32'(busy), 32'(m_state != M_IDLE));
        check_eq("frame_done", 32'(frame_done), 32'(m_done));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("sync_err", 32'(sync_err), 32'(m_sync));
`ifdef PIX_PACK_DROP_CNT_EN
        check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drops));
        check_eq("frame_cnt", 32'(frame_cnt), 32'(m_frames & 16'hFFFF));
`endif
        if (frame_done === 1'b1) done_seen++;
    endtask

    // One clock: drive at the falling edge, model at the rising edge, compare at the next falling edge
    task automatic step(input logic rst, input logic fs, input logic pv, input logic [7:0] pd, input logic rdy);
        reset           = rst;
        bus.frame_start = fs;
        bus.pix_valid   = pv;
        bus.pix_data    = pd;
        bus.wr_rdy      = rdy;
        if (!rst && bus.mem_wr_req_n === 1'b0 && rdy) dut_words.push_back(bus.mem_wr_data);
        @(posedge wr_clk);
        model_clock();
        @(negedge wr_clk);
        compare_outputs();
    endtask

    task automatic px(input logic fs, input logic [7:0] pd, input logic rdy);
        step(1'b0, fs, 1'b1, pd, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, rdy);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        dut_words.delete();
        done_seen = 0;
    endtask

    task automatic frame_seq(input logic [7:0] base, input int n, input logic rdy);
        for (int i = 0; i < n; i++) px((i == 0) ? 1'b1 : 1'b0, base + 8'(i), rdy);
    endtask

    initial begin
        bus.frame_start = 1'b0; bus.pix_valid = 1'b0; bus.pix_data = 8'h00; bus.wr_rdy = 1'b0;
        reset = 1'b1;
        done_seen = 0;
        @(negedge wr_clk);

        // Reset values
        do_reset();
        check_eq("rst_req_n", 32'(bus.mem_wr_req_n), 32'd1);
        check_eq("rst_data", bus.mem_wr_data, 32'h0);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        check_eq("rst_flags", {28'h0, busy, frame_done, overflow, sync_err}, 32'h0);

        // Basic 10-pixel frame with wr_rdy held high
        frame_seq(8'h01, 3, 1'b1);
        check_eq("req_n_before_w0", 32'(bus.mem_wr_req_n), 32'd1);
        px(1'b0, 8'h04, 1'b1);
        check_eq("req_n_after_w0", 32'(bus.mem_wr_req_n), 32'd0);
        for (int i = 5; i <= 10; i++) px(1'b0, 8'(i), 1'b1);
        idle(8, 1'b1);
        check_eq("basic_nwords", 32'(dut_words.size()), 32'd3);
        if (dut_words.size() == 3) begin
            check_eq("basic_w0", dut_words[0], 32'h04030201);
            check_eq("basic_w1", dut_words[1], 32'h08070605);
            check_eq("basic_w2", dut_words[2], 32'h00000A09);
        end
        check_eq("basic_done", 32'(done_seen), 32'd1);
        check_eq("basic_busy", 32'(busy), 32'd0);

        // Overflow: three frames with wr_rdy low, then release
        do_reset();
        frame_seq(8'h01, 10, 1'b0); idle(1, 1'b0);
        frame_seq(8'h11, 10, 1'b0); idle(1, 1'b0);
        frame_seq(8'h21, 10, 1'b0); idle(1, 1'b0);
        check_eq("ovf_level", 32'(fifo_level), 32'd4);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
`ifdef PIX_PACK_DROP_CNT_EN
        check_eq("ovf_drop_cnt", 32'(drop_cnt), 32'd5);
`endif
        idle(10, 1'b1);
        check_eq("ovf_nwords", 32'(dut_words.size()), 32'd4);
        if (dut_words.size() == 4) begin
            check_eq("ovf_w0", dut_words[0], 32'h04030201);
            check_eq("ovf_w3", dut_words[3], 32'h14131211);
        end

        // Full FIFO popped on the same edge a word completes
        do_reset();
        frame_seq(8'h01, 10, 1'b0); idle(1, 1'b0);
        frame_seq(8'h21, 7, 1'b0);
        check_eq("full_level_pre", 32'(fifo_level), 32'd4);
        px(1'b0, 8'h28, 1'b1);
        check_eq("full_level_post", 32'(fifo_level), 32'd4);
        check_eq("full_ovf", 32'(overflow), 32'd0);
        px(1'b0, 8'h29, 1'b1);
        px(1'b0, 8'h2A, 1'b1);
        idle(12, 1'b1);
        check_eq("full_nwords", 32'(dut_words.size()), 32'd6);
        if (dut_words.size() == 6) begin
            check_eq("full_w3", dut_words[3], 32'h24232221);
            check_eq("full_w4", dut_words[4], 32'h28272625);
            check_eq("full_w5", dut_words[5], 32'h00002A29);
        end
        check_eq("full_done", 32'(done_seen), 32'd1);

        // frame_start after pixel 6 aborts the frame
        do_reset();
        frame_seq(8'h01, 6, 1'b1);
        frame_seq(8'h31, 10, 1'b1);
        idle(10, 1'b1);
        check_eq("sync_flag", 32'(sync_err), 32'd1);
        check_eq("sync_nwords", 32'(dut_words.size()), 32'd4);
        if (dut_words.size() == 4) begin
            check_eq("sync_w0", dut_words[0], 32'h04030201);
            check_eq("sync_w1", dut_words[1], 32'h34333231);
            check_eq("sync_w3", dut_words[3], 32'h00003A39);
        end
        check_eq("sync_done", 32'(done_seen), 32'd1);

        // Reset with three words queued and the request asserted
        frame_seq(8'h01, 10, 1'b0); idle(1, 1'b0);
        check_eq("rq_level", 32'(fifo_level), 32'd3);
        check_eq("rq_req_n", 32'(bus.mem_wr_req_n), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check_eq("rq_req_n_after", 32'(bus.mem_wr_req_n), 32'd1);
        check_eq("rq_level_after", 32'(fifo_level), 32'd0);
        check_eq("rq_flags_after", {29'h0, busy, overflow, sync_err}, 32'h0);

        // frame_start with a pixel in IDLE: that pixel is lane 0
        do_reset();
        px(1'b1, 8'hAA, 1'b1);
        for (int i = 1; i < 10; i++) px(1'b0, 8'(8'hB0 + i), 1'b1);
        idle(8, 1'b1);
        check_eq("aa_nwords", 32'(dut_words.size()), 32'd3);
        if (dut_words.size() != 0) begin
            check_eq("aa_lsb", 32'(dut_words[0][7:0]), 32'h000000AA);
        end

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic rst_s, fs_s, pv_s, rdy_s;
            rst_s = ($urandom_range(0, 499) == 0);
            fs_s  = (m_state == M_IDLE) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 69) == 0);
            pv_s  = ($urandom_range(0, 9) < 7);
            rdy_s = ((c / 200) % 3 == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
            step(rst_s, fs_s, pv_s, 8'($urandom), rdy_s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
